// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller and the BCD counter it drives.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        PAUSE  = 2'b01,
        ADJUST = 2'b10
    } state_e;

    // Adjust field select as seen on adj_sel
    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

    // Counter width for a divisor, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Board-input / counter-enable bundle between the controller and its surroundings.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic   btn_rst;
    logic   btn_pause;
    logic   sw_adj;
    logic   sw_sel;
    logic   clear;
    logic   tick_en;
    logic   adj_en;
    logic   adj_sel;
    state_e mode;
    logic   blink;

    // Board and counter side
    modport master (
        output btn_rst, btn_pause, sw_adj, sw_sel,
        input  clear, tick_en, adj_en, adj_sel, mode, blink
    );

    // Controller side
    modport slave (
        input  btn_rst, btn_pause, sw_adj, sw_sel,
        output clear, tick_en, adj_en, adj_sel, mode, blink
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer for one raw input.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    // Accept a new level only after it has differed for DB_CYCLES straight cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_q[1] != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// RUN/PAUSE/ADJUST sequencer producing single-cycle enables for the stopwatch counter.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned ADJ_DIV   = 50_000_000,
    parameter int unsigned BLINK_DIV = 25_000_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input logic             clk,
    input logic             reset,
    stopwatch_ctrl_if.slave bus
);

    localparam int unsigned TW = cnt_width(TICK_DIV);
    localparam int unsigned AW = cnt_width(ADJ_DIV);
    localparam int unsigned BW = cnt_width(BLINK_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADJ_LAST   = AW'(ADJ_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic db_rst, db_pause, db_adj, db_sel;
    logic rst_prev_q, pause_prev_q;
    logic rst_press, pause_press;

    state_e        state_q;
    logic [TW-1:0] tick_div_q;
    logic [AW-1:0] adj_div_q;
    logic [BW-1:0] blink_div_q;
    logic          clear_q, tick_en_q, adj_en_q, adj_sel_q, blink_q;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
        .clk(clk), .reset(reset), .raw(bus.btn_rst), .level(db_rst)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk(clk), .reset(reset), .raw(bus.btn_pause), .level(db_pause)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_adj (
        .clk(clk), .reset(reset), .raw(bus.sw_adj), .level(db_adj)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
        .clk(clk), .reset(reset), .raw(bus.sw_sel), .level(db_sel)
    );

    // Previous debounced button levels for rising-edge press detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_prev_q   <= 1'b0;
            pause_prev_q <= 1'b0;
        end else begin
            rst_prev_q   <= db_rst;
            pause_prev_q <= db_pause;
        end
    end

    assign rst_press   = db_rst & ~rst_prev_q;
    assign pause_press = db_pause & ~pause_prev_q;

    // State machine, dividers and registered outputs; clear beats sw_adj beats btn_pause
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PAUSE;
            tick_div_q  <= '0;
            adj_div_q   <= '0;
            blink_div_q <= '0;
            clear_q     <= 1'b0;
            tick_en_q   <= 1'b0;
            adj_en_q    <= 1'b0;
            adj_sel_q   <= SEL_MIN;
            blink_q     <= 1'b0;
        end else begin
            clear_q   <= rst_press;
            tick_en_q <= 1'b0;
            adj_en_q  <= 1'b0;
            adj_sel_q <= db_sel;
            if (rst_press) begin
                tick_div_q <= '0;
                adj_div_q  <= '0;
            end
            case (state_q)
                RUN, PAUSE: begin
                    if (db_adj) begin
                        // Entry wins over a coincident pause press, which is dropped
                        state_q     <= ADJUST;
                        tick_div_q  <= '0;
                        adj_div_q   <= '0;
                        blink_div_q <= '0;
                        blink_q     <= 1'b0;
                    end else begin
                        // PAUSE leaves the tick divider alone to keep the partial second
                        if (state_q == RUN && !rst_press) begin
                            if (tick_div_q == TICK_LAST) begin
                                tick_en_q  <= 1'b1;
                                tick_div_q <= '0;
                            end else begin
                                tick_div_q <= tick_div_q + 1'b1;
                            end
                        end
                        if (pause_press) begin
                            state_q <= (state_q == RUN) ? PAUSE : RUN;
                        end
                    end
                end
                ADJUST: begin
                    if (!db_adj) begin
                        state_q     <= PAUSE;
                        blink_q     <= 1'b0;
                        blink_div_q <= '0;
                    end else begin
                        if (!rst_press) begin
                            if (adj_div_q == ADJ_LAST) begin
                                adj_en_q  <= 1'b1;
                                adj_div_q <= '0;
                            end else begin
                                adj_div_q <= adj_div_q + 1'b1;
                            end
                        end
                        if (blink_div_q == BLINK_LAST) begin
                            blink_q     <= ~blink_q;
                            blink_div_q <= '0;
                        end else begin
                            blink_div_q <= blink_div_q + 1'b1;
                        end
                    end
                end
                default: state_q <= PAUSE;
            endcase
        end
    end

    assign bus.clear   = clear_q;
    assign bus.tick_en = tick_en_q;
    assign bus.adj_en  = adj_en_q;
    assign bus.adj_sel = adj_sel_q;
    assign bus.mode    = state_q;
    assign bus.blink   = blink_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed-vector bench for stopwatch_ctrl with small divisors.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int unsigned TICK  = 10;
    localparam int unsigned ADJ   = 5;
    localparam int unsigned BLINK = 3;
    localparam int unsigned DB    = 4;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(
        .TICK_DIV (TICK),
        .ADJ_DIV  (ADJ),
        .BLINK_DIV(BLINK),
        .DB_CYCLES(DB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Observed outputs: {mode[1:0], clear, tick_en, adj_en, adj_sel, blink}
    logic [6:0] outs;
    assign outs = {bus.mode, bus.clear, bus.tick_en, bus.adj_en, bus.adj_sel, bus.blink};

    function automatic logic [6:0] pack(input logic [1:0] m, input logic c, input logic t,
                                        input logic a, input logic s, input logic b);
        return {m, c, t, a, s, b};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        step(2);
        exp = pack(PAUSE, 0, 0, 0, 0, 0);
        vectors++;
        if (outs !== exp) begin
            $display("FAIL reset_initial got %b want %b", outs, exp);
            miscompares++;
        end
        reset = 1'b1;
        bus.btn_pause = 1'b1;
        step(7);
        vectors++;
        if (bus.mode !== RUN) begin
            $display("FAIL reset_prerun mode got %b want %b", bus.mode, RUN);
            miscompares++;
        end
        step(3);
        bus.btn_pause = 1'b0;
        step(8);
        reset = 1'b0;
        #1;
        vectors++;
        if (outs !== exp) begin
            $display("FAIL reset_midrun got %b want %b", outs, exp);
            miscompares++;
        end
        step(2);
        reset = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step(1);
            vectors++;
            if (outs !== exp) begin
                $display("FAIL reset_idle cycle %0d got %b want %b", i, outs, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_run_ticks();
        logic [6:0] exp;
        bus.btn_pause = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 21) bus.btn_pause = 1'b0;
            step(1);
            exp = pack((i >= 7) ? RUN : PAUSE, 0, (i >= 17) && ((i - 7) % 10 == 0), 0, 0, 0);
            vectors++;
            if (outs !== exp) begin
                $display("FAIL run_ticks cycle %0d got %b want %b", i, outs, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_pause_hold();
        logic [6:0] exp;
        int found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step(1);
            if (bus.tick_en === 1'b1) found = 1;
        end
        vectors++;
        if (found == 0) begin
            $display("FAIL pause_sync got no tick_en want tick_en within 20 cycles");
            miscompares++;
        end
        step(7);
        bus.btn_pause = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            exp = pack((i == 7) ? PAUSE : RUN, 0, i == 3, 0, 0, 0);
            vectors++;
            if (outs !== exp) begin
                $display("FAIL pause_enter cycle %0d got %b want %b", i, outs, exp);
                miscompares++;
            end
        end
        step(3);
        bus.btn_pause = 1'b0;
        exp = pack(PAUSE, 0, 0, 0, 0, 0);
        for (int i = 0; i < 50; i++) begin
            step(1);
            vectors++;
            if (outs !== exp) begin
                $display("FAIL pause_hold cycle %0d got %b want %b", i, outs, exp);
                miscompares++;
            end
        end
        bus.btn_pause = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            step(1);
            exp = pack((i >= 7) ? RUN : PAUSE, 0, i == 13, 0, 0, 0);
            vectors++;
            if (outs !== exp) begin
                $display("FAIL pause_resume cycle %0d got %b want %b", i, outs, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_bounce();
        int changes = 0;
        logic [1:0] prev;
        bus.btn_pause = 1'b0;
        step(10);
        prev = bus.mode;
        for (int i = 0; i < 30; i++) begin
            bus.btn_pause = ((i / 2) % 2 == 0);
            step(1);
            if (bus.mode !== prev) changes++;
            prev = bus.mode;
        end
        vectors++;
        if (bus.mode !== RUN) begin
            $display("FAIL bounce_glitch mode got %b want %b", bus.mode, RUN);
            miscompares++;
        end
        bus.btn_pause = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bus.mode !== prev) changes++;
            prev = bus.mode;
        end
        vectors++;
        if (changes != 1) begin
            $display("FAIL bounce_changes got %0d want 1", changes);
            miscompares++;
        end
        vectors++;
        if (bus.mode !== PAUSE) begin
            $display("FAIL bounce_final mode got %b want %b", bus.mode, PAUSE);
            miscompares++;
        end
        bus.btn_pause = 1'b0;
        step(10);
    endtask

    task automatic test_adjust();
        logic [6:0] exp;
        int k;
        bus.sw_sel = SEL_SEC;
        bus.sw_adj = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            exp = pack((i >= 7) ? ADJUST : PAUSE, 0, 0, (i >= 12) && ((i - 7) % 5 == 0),
                       i >= 7, (i >= 10) && (((i - 10) / 3) % 2 == 0));
            vectors++;
            if (outs !== exp) begin
                $display("FAIL adjust_run cycle %0d got %b want %b", i, outs, exp);
                miscompares++;
            end
        end
        bus.sw_adj = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            k = 20 + j;
            step(1);
            exp = pack((j == 7) ? PAUSE : ADJUST, 0, 0, (j < 7) && ((k - 7) % 5 == 0),
                       1, (j < 7) && (((k - 10) / 3) % 2 == 0));
            vectors++;
            if (outs !== exp) begin
                $display("FAIL adjust_exit cycle %0d got %b want %b", j, outs, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_clear();
        logic [6:0] exp;
        bus.btn_pause = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 11) bus.btn_pause = 1'b0;
            if (i == 13) bus.btn_rst = 1'b1;
            if (i == 21) bus.btn_rst = 1'b0;
            step(1);
            exp = pack((i >= 7) ? RUN : PAUSE, i == 19, (i == 17) || (i == 29) || (i == 39),
                       0, 1, 0);
            vectors++;
            if (outs !== exp) begin
                $display("FAIL clear_run cycle %0d got %b want %b", i, outs, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        bus.btn_rst   = 1'b1;
        bus.btn_pause = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            exp = pack((i >= 7) ? PAUSE : RUN, i == 7, 0, 0, 1, 0);
            vectors++;
            if (outs !== exp) begin
                $display("FAIL clear_and_pause cycle %0d got %b want %b", i, outs, exp);
                miscompares++;
            end
        end
        bus.btn_rst   = 1'b0;
        bus.btn_pause = 1'b0;
        step(10);
    endtask

    initial begin
        reset         = 1'b0;
        bus.btn_rst   = 1'b0;
        bus.btn_pause = 1'b0;
        bus.sw_adj    = 1'b0;
        bus.sw_sel    = 1'b0;
        test_reset();
        test_run_ticks();
        test_pause_hold();
        test_bounce();
        test_adjust();
        test_clear();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "bench timed out");
    end

endmodule
